// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: pops bytes and packs LANES of them into one
// wide word on a valid/ready output, with a flush that emits any partial word.
module fifo_rd_packer #(
   parameter int RAM_WIDTH = 8,
   parameter int LANES     = 4
) (
   input  logic                       r_clk,
   input  logic                       r_rst,
   input  logic                       r_empty,
   input  logic [RAM_WIDTH-1:0]       r_data,
   output logic                       r_req,
   input  logic                       flush,
   output logic [RAM_WIDTH*LANES-1:0] out_data,
   output logic [LANES-1:0]           out_keep,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       idle
);

   localparam int CW = $clog2(LANES + 1);

   logic [RAM_WIDTH-1:0]       asm_q [LANES];
   logic [CW-1:0]              cnt;
   logic                       pend;
   logic                       flush_pend;
   logic [CW:0]                fill;
   logic                       full;
   logic                       xfer;
   logic                       flush_done;
   logic [RAM_WIDTH*LANES-1:0] word_nxt;
   logic [LANES-1:0]           keep_nxt;

   // Bytes already held plus the one in flight must leave room in the word before popping.
   always_comb begin
      fill       = {1'b0, cnt} + {{CW{1'b0}}, pend};
      r_req      = !r_empty && !flush_pend && (fill < (CW+1)'(LANES)) && !r_rst;
      full       = (cnt == CW'(LANES));
      xfer       = (full || (flush_pend && !pend && (cnt != '0))) && (!out_valid || out_ready);
      flush_done = flush_pend && !pend && (cnt == '0);
      idle       = (cnt == '0) && !pend && !flush_pend && !out_valid;
   end

   // Lanes at or above cnt are unused: zero data and clear keep.
   always_comb begin
      word_nxt = '0;
      keep_nxt = '0;
      for (int i = 0; i < LANES; i++) begin
         keep_nxt[i] = (CW'(i) < cnt);
         word_nxt[i*RAM_WIDTH +: RAM_WIDTH] = keep_nxt[i] ? asm_q[i] : '0;
      end
   end

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         for (int i = 0; i < LANES; i++) asm_q[i] <= '0;
         cnt        <= '0;
         pend       <= 1'b0;
         flush_pend <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_valid  <= 1'b0;
      end else begin
         pend <= r_req;

         // Transfer only fires with pend low, so it never collides with a capture.
         if (xfer) begin
            cnt <= '0;
         end else if (pend) begin
            for (int i = 0; i < LANES; i++)
               if (CW'(i) == cnt) asm_q[i] <= r_data;
            cnt <= cnt + CW'(1);
         end

         if (!flush_pend)
            flush_pend <= flush;
         else if (xfer || flush_done)
            flush_pend <= 1'b0;

         if (xfer) begin
            out_data  <= word_nxt;
            out_keep  <= keep_nxt;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, in the read clock domain.
- Pops bytes through the FIFO's r_req/r_data/r_empty interface and packs LANES consecutive bytes into one wide word.
- Presents each word on a valid/ready output with a per-lane keep mask.
- A flush request emits any partial word, so packet tails are not stranded.

Parameters:
- RAM_WIDTH, 8, byte width; must match the FIFO data width.
- LANES, 4, bytes per output word; valid values 2..8.

Ports:
- r_clk  in  1  read-domain clock; all logic on the rising edge.
- r_rst  in  1  synchronous reset, active-high.
- r_empty  in  1  FIFO empty flag.
- r_data  in  RAM_WIDTH  FIFO read data; valid the cycle after a pop.
- r_req  out  1  FIFO pop request; one byte per cycle while high.
- flush  in  1  single-cycle pulse requesting emission of the partial word.
- out_data  out  RAM_WIDTH*LANES  packed word; lane 0 is the LSBs and holds the first byte.
- out_keep  out  LANES  lane-valid mask; bit i covers lane i.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- idle  out  1  high when there is no assembly data, no pop in flight, no flush pending and no output held.

Behaviour:
- Reset (r_rst=1 at an edge): all of the following clear to 0:
  - r_req, out_valid, out_data, out_keep;
  - assembly register, cnt, pend, flush_pend.
  - idle = 1 after reset.
  - A byte already in flight at reset is discarded; it is not captured after reset releases.
- State:
  - assembly register asm[LANES];
  - cnt, 0..LANES: bytes held in asm;
  - pend, 1 bit: pop issued last cycle;
  - flush_pend, 1 bit;
  - output register (out_data, out_keep, out_valid).
- Pop rule (combinational, registered-free):
  - r_req = !r_empty & !flush_pend & (cnt + pend < LANES) & !r_rst.
  - pend <= r_req.
- Capture: if pend, then asm[cnt] <= r_data and cnt <= cnt+1.
- Transfer asm to output:
  - Occurs when (cnt==LANES, or flush_pend & !pend & cnt>0) and (!out_valid | out_ready).
  - Loads out_data = asm with unused lanes zero-filled.
  - out_keep = (1<<cnt)-1 for a partial word; all ones for a full word.
  - Sets out_valid=1, cnt<=0, flush_pend<=0.
- Capture and transfer are never in the same cycle: cnt==LANES implies pend=0.
- Output handshake:
  - A word is accepted on a cycle where out_valid & out_ready.
  - out_valid drops next cycle unless a transfer reloads it in the same cycle (back-to-back allowed).
  - out_data and out_keep are stable while out_valid & !out_ready.
- Latency and throughput (out_ready=1, FIFO non-empty from cycle 0, LANES=4):
  - pops in cycles 0-3;
  - captures at the end of cycles 1-4;
  - cnt==4 in cycle 5, transfer at the end of cycle 5;
  - out_valid high in cycle 6;
  - next pop in cycle 6.
  - Sustained rate is LANES bytes per LANES+2 cycles.
- Flush:
  - flush sets flush_pend, which blocks new pops.
  - Completes once pend=0:
    - cnt>0: partial transfer.
    - cnt==0: flush_pend clears with no output.
    - cnt==LANES: the normal full transfer clears flush_pend; no extra word.
  - Flush while flush_pend=1 is ignored.
  - Flush with the output held waits for the transfer condition.
- Backpressure: with out_valid & !out_ready and asm full, pops stop (cnt+pend==LANES); no byte is lost or duplicated.
- r_empty mid-word: pops pause and cnt holds; packing resumes when data returns. There is no timeout; only flush emits a partial word.

Test Plan:
- Reset then idle, FIFO empty: r_req=0, out_valid=0, idle=1 for 20 cycles.
- FIFO preloaded with bytes 0..17 (LANES=4), out_ready=1:
  - words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, each keep=4'b1111;
  - then pops stop with cnt=2;
  - flush -> 0x00001110, keep=4'b0011, then idle=1.
- Timing check on the first word: first r_req in cycle 0 -> out_valid first high in cycle 6; r_req low in cycles 4-5.
- out_ready=0 for 15 cycles with 12 bytes available:
  - out_valid stays high with 0x03020100 stable;
  - exactly 8 bytes are popped;
  - releasing out_ready yields 0x07060504 next cycle, then 0x0B0A0908, with no loss.
- Flush with cnt=0, pend=0 -> no output word; flush on the same cycle as the third pop -> the in-flight byte is captured, then a 3-lane word is emitted with keep=4'b0111.
- r_rst asserted mid-word (cnt=2, pend=1) -> next cycle all outputs are 0; after release, new bytes 0xA0..0xA3 give 0xA3A2A1A0, proving the in-flight byte was dropped.
